// File: rtl/game_session_ctrl_if.sv
// game_session_ctrl_if: login, round and score-table signals of the session
// sequencer. "master" is the environment (login logic, pattern logic, score
// table view); "slave" is game_session_ctrl.
// Handshake: green_user, auth_bit and user_logout are levels sampled on the
// rising clock edge in the states that accept them; round_done is a one-cycle
// strobe qualified by round_pass; round_start, win, loose and log_out are
// one-cycle strobes from registers, so they never depend combinationally on
// any input.
interface game_session_ctrl_if;
  logic       green_user;
  logic [2:0] internal_id;
  logic       auth_bit;
  logic       user_logout;
  logic       round_done;
  logic       round_pass;
  logic       round_start;
  logic [3:0] level_num;
  logic       win;
  logic       loose;
  logic       log_out;
  logic [2:0] user_id;
  logic [1:0] lives;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output green_user, internal_id, auth_bit, user_logout, round_done, round_pass,
    input  round_start, level_num, win, loose, log_out, user_id, lives, busy, state_dbg
  );

  modport slave (
    input  green_user, internal_id, auth_bit, user_logout, round_done, round_pass,
    output round_start, level_num, win, loose, log_out, user_id, lives, busy, state_dbg
  );
endinterface

// File: rtl/game_session_ctrl.sv
// game_session_ctrl: session sequencer for the memory-tester game.
// Login -> authentication -> level rounds with settle/gap spacing -> end.
// Optional feature macro ROUND_TIMEOUT_EN: a round left unanswered for
// TIMEOUT_CYCLES cycles in PLAY counts as a failed round.
// Timing: the win/loose cycle is the first of GAP RESULT cycles, so game-over
// log_out lands GAP cycles after loose and the next round_start lands
// GAP+1+SETTLE+1 cycles after the pulse, counting both end cycles.
module game_session_ctrl #(
  parameter int MAX_LEVEL      = 5,
  parameter int MAX_LIVES      = 3,
  parameter int SETTLE         = 2,
  parameter int GAP            = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               rst,
  game_session_ctrl_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE, S_AUTH, S_LOAD, S_SETTLE_W, S_PLAY, S_RESULT, S_END
  } state_t;

  localparam int CNT_W = 8;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       level_q, level_d;
  logic [1:0]       lives_q, lives_d;
  logic [2:0]       user_id_q, user_id_d;
  logic             win_q, win_d;
  logic             loose_q, loose_d;
  logic             log_out_q, log_out_d;
  logic             round_start_q, round_start_d;
  logic             timeout;
  logic             in_round;
  logic             end_session;

  // States in which user_logout aborts the running round.
  assign in_round = (state_q == S_LOAD) || (state_q == S_SETTLE_W) ||
                    (state_q == S_PLAY) || (state_q == S_RESULT);

`ifdef ROUND_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q;

  assign timeout = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Round timer: counts cycles spent in PLAY, cleared whenever PLAY is left.
  always_ff @(posedge clock) begin
    if (!rst) begin
      timer_q <= '0;
    end else if ((state_q == S_PLAY) && (state_d == S_PLAY)) begin
      timer_q <= timer_q + TMR_W'(1);
    end else begin
      timer_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, session bookkeeping and registered strobe requests.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    level_d       = level_q;
    lives_d       = lives_q;
    user_id_d     = user_id_q;
    win_d         = 1'b0;
    loose_d       = 1'b0;
    log_out_d     = 1'b0;
    round_start_d = 1'b0;
    end_session   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sif.green_user) begin
          user_id_d = sif.internal_id;
          state_d   = S_AUTH;
        end
      end
      S_AUTH: begin
        if (sif.user_logout) begin
          end_session = 1'b1;
        end else if (sif.auth_bit) begin
          level_d = 4'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SETTLE_W;
      end
      S_SETTLE_W: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d         = '0;
          round_start_d = 1'b1;
          state_d       = S_PLAY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PLAY: begin
        if (sif.round_done || timeout) begin
          cnt_d   = '0;
          state_d = S_RESULT;
          if (sif.round_done && sif.round_pass) begin
            win_d   = 1'b1;
            level_d = (level_q == 4'(MAX_LEVEL)) ? 4'd1 : level_q + 4'd1;
          end else begin
            loose_d = 1'b1;
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          end
        end
      end
      S_RESULT: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d = '0;
          if (lives_q == 2'd0) begin
            end_session = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Logout wins over a simultaneous result: the round is dropped unscored.
    if (in_round && sif.user_logout) begin
      end_session = 1'b1;
    end

    if (end_session) begin
      state_d       = S_END;
      log_out_d     = 1'b1;
      win_d         = 1'b0;
      loose_d       = 1'b0;
      round_start_d = 1'b0;
      level_d       = 4'd0;
      lives_d       = 2'(MAX_LIVES);
      user_id_d     = 3'd0;
      cnt_d         = '0;
    end
  end

  // State and session registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      level_q       <= 4'd0;
      lives_q       <= 2'(MAX_LIVES);
      user_id_q     <= 3'd0;
      win_q         <= 1'b0;
      loose_q       <= 1'b0;
      log_out_q     <= 1'b0;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      user_id_q     <= user_id_d;
      win_q         <= win_d;
      loose_q       <= loose_d;
      log_out_q     <= log_out_d;
      round_start_q <= round_start_d;
    end
  end

  assign sif.round_start = round_start_q;
  assign sif.level_num   = level_q;
  assign sif.win         = win_q;
  assign sif.loose       = loose_q;
  assign sif.log_out     = log_out_q;
  assign sif.user_id     = user_id_q;
  assign sif.lives       = lives_q;
  assign sif.busy        = (state_q != S_IDLE);
  assign sif.state_dbg   = state_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: randomized bench for game_session_ctrl. A session
// model predicts each strobe (kind, cycle, level, lives, user id) and queues
// it; the monitor pops one entry per strobe the DUT shows.
module tb_game_session_ctrl;
  localparam int MAX_LEVEL      = 5;
  localparam int MAX_LIVES      = 3;
  localparam int SETTLE         = 2;
  localparam int GAP            = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int EW             = 43;

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_WIN   = 2'd1;
  localparam logic [1:0] K_LOOSE = 2'd2;
  localparam logic [1:0] K_LOG   = 2'd3;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [EW-1:0] exp_q[$];

  // Session model: plain counters following the game rules.
  int m_level  = 0;
  int m_lives  = MAX_LIVES;
  int m_uid    = 0;
  int m_start_t = 0;
  int m_idle_t = 0;
  bit m_active = 1'b0;

  game_session_ctrl_if sif();

  game_session_ctrl #(
    .MAX_LEVEL(MAX_LEVEL), .MAX_LIVES(MAX_LIVES), .SETTLE(SETTLE),
    .GAP(GAP), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .rst(rst),
    .sif(sif)
  );

  // Clock and cycle index (cycle n = the period following rising edge n).
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  function automatic logic [EW-1:0] pack(input logic [1:0] k, input int t,
                                         input logic [3:0] l, input logic [1:0] lv,
                                         input logic [2:0] u);
    return {k, l, lv, u, 32'(t)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest prediction exactly.
  always @(negedge clock) begin
    logic [3:0]    p;
    logic [1:0]    k;
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    p = {sif.log_out, sif.loose, sif.win, sif.round_start};
    if (p != 4'd0) begin
      chk("strobe_onehot", 64'($countones(p)), 64'd1);
      k = p[3] ? K_LOG : p[2] ? K_LOOSE : p[1] ? K_WIN : K_START;
      got = pack(k, cyc, sif.level_num, sif.lives, sif.user_id);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none", k, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL strobe: got kind %0d t %0d lvl %0d lives %0d uid %0d, expected kind %0d t %0d lvl %0d lives %0d uid %0d",
                   got[42:41], got[31:0], got[40:37], got[36:35], got[34:32],
                   want[42:41], want[31:0], want[40:37], want[36:35], want[34:32]);
        end
      end
    end else if (exp_q.size() != 0) begin
      want = exp_q[0];
      if (int'(want[31:0]) < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_strobe: got none by cycle %0d, expected kind %0d at t %0d",
                 cyc, want[42:41], want[31:0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic push(input logic [1:0] k, input int t);
    exp_q.push_back(pack(k, t, 4'(m_level), 2'(m_lives), 3'(m_uid)));
  endtask

  task automatic end_model();
    m_level  = 0;
    m_lives  = MAX_LIVES;
    m_uid    = 0;
    m_active = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(sif.busy), 64'd0);
    chk({tag, "_level"}, 64'(sif.level_num), 64'd0);
    chk({tag, "_lives"}, 64'(sif.lives), 64'(MAX_LIVES));
    chk({tag, "_uid"}, 64'(sif.user_id), 64'd0);
  endtask

  // Round outcome scored at cycle m.
  task automatic model_result(input bit pass, input int m);
    if (pass) begin
      m_level = (m_level == MAX_LEVEL) ? 1 : m_level + 1;
      push(K_WIN, m);
    end else begin
      if (m_lives > 0) m_lives--;
      push(K_LOOSE, m);
    end
    if (!pass && m_lives == 0) begin
      end_model();
      push(K_LOG, m + GAP);
      m_idle_t = m + GAP + 1;
    end else begin
      m_start_t = m + GAP + SETTLE + 1;
      push(K_START, m_start_t);
    end
  endtask

  task automatic login(input int id, input int auth_wait, input bit noise);
    wait_until(m_idle_t);
    sif.green_user  = 1'b1;
    sif.internal_id = 3'(id);
    tick();
    sif.green_user  = 1'b0;
    sif.internal_id = 3'($urandom);
    m_uid = id;
    repeat (auth_wait) begin
      sif.round_done = noise & 1'($urandom);
      sif.round_pass = 1'($urandom);
      tick();
      sif.round_done = 1'b0;
    end
  endtask

  task automatic auth();
    sif.auth_bit = 1'b1;
    m_level  = 1;
    m_lives  = MAX_LIVES;
    m_active = 1'b1;
    m_start_t = cyc + 2 + SETTLE;
    push(K_START, m_start_t);
    tick();
    sif.auth_bit = 1'b0;
  endtask

  task automatic play_round(input bit pass, input bit noise);
    int m;
    wait_until(m_start_t);
    repeat ($urandom_range(0, 3)) tick();
    sif.round_done = 1'b1;
    sif.round_pass = pass;
    m = cyc + 1;
    model_result(pass, m);
    tick();
    sif.round_done = 1'b0;
    sif.round_pass = 1'($urandom);
    if (noise) begin
      sif.round_done = 1'b1;
      sif.round_pass = 1'b1;
      tick();
      sif.round_done = 1'b0;
    end
  endtask

  task automatic logout(input bit collide);
    int k;
    logic [EW-1:0] tail;
    sif.user_logout = 1'b1;
    if (collide) begin
      sif.round_done = 1'b1;
      sif.round_pass = 1'b1;
    end
    k = cyc + 1;
    while (exp_q.size() > 0) begin
      tail = exp_q[exp_q.size() - 1];
      if (int'(tail[31:0]) < k) break;
      void'(exp_q.pop_back());
    end
    end_model();
    push(K_LOG, k);
    m_idle_t = k + 1;
    tick();
    sif.user_logout = 1'b0;
    sif.round_done  = 1'b0;
    wait_until(m_idle_t);
    check_idle("after_logout");
  endtask

  // Test sequence.
  initial begin
    sif.green_user  = 1'b0;
    sif.internal_id = 3'd0;
    sif.auth_bit    = 1'b0;
    sif.user_logout = 1'b0;
    sif.round_done  = 1'b0;
    sif.round_pass  = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    chk("reset_strobes", 64'({sif.round_start, sif.win, sif.loose, sif.log_out}), 64'd0);
    rst = 1'b1;
    tick();

    // Login id 5 and five passes: level 1..5 then wraps to 1.
    login(5, 1, 1'b0);
    auth();
    for (int i = 0; i < 5; i++) play_round(1'b1, i == 2);
    chk("level_wrap", 64'(sif.level_num), 64'd1);
    chk("user_id_latched", 64'(sif.user_id), 64'd5);
    // Logout colliding with a passing round_done.
    wait_until(m_start_t);
    logout(1'b1);

    // Lives exhausted at level 2.
    login($urandom_range(0, 7), 2, 1'b1);
    auth();
    play_round(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      play_round(1'b0, 1'b1);
      chk("fail_level_hold", 64'(sif.level_num), 64'd2);
      chk("fail_lives", 64'(sif.lives), 64'(2 - i));
    end
    wait_until(m_idle_t);
    check_idle("game_over");

    // Reset in PLAY at level 3.
    login(3, 0, 1'b0);
    auth();
    play_round(1'b1, 1'b0);
    play_round(1'b1, 1'b0);
    wait_until(m_start_t);
    tick();
    chk("pre_reset_level", 64'(sif.level_num), 64'd3);
    rst = 1'b0;
    tick();
    check_idle("mid_reset");
    chk("mid_reset_strobes", 64'({sif.round_start, sif.win, sif.loose, sif.log_out}), 64'd0);
    chk("mid_reset_queue", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    end_model();
    m_idle_t = cyc;
    tick();

`ifdef ROUND_TIMEOUT_EN
    // Unanswered round times out as a fail.
    login(2, 0, 1'b0);
    auth();
    wait_until(m_start_t);
    model_result(1'b0, m_start_t + TIMEOUT_CYCLES);
    wait_until(m_start_t);
    chk("timeout_lives", 64'(sif.lives), 64'(MAX_LIVES - 1));
    logout(1'b0);
`endif

    // Random sessions ending by logout (AUTH, RESULT, PLAY) or game over.
    for (int s = 0; s < 8; s++) begin
      int kind;
      kind = $urandom_range(0, 3);
      login($urandom_range(0, 7), $urandom_range(0, 2), 1'($urandom));
      if (kind == 0) begin
        logout(1'b0);
      end else begin
        auth();
        for (int r = 0; r < 10 && m_active; r++) play_round(1'($urandom), 1'($urandom));
        if (m_active) begin
          if (kind == 1) logout(1'b0);
          else begin
            wait_until(m_start_t);
            logout(1'($urandom));
          end
        end else begin
          wait_until(m_idle_t);
          check_idle("rand_over");
        end
      end
    end

    repeat (5) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_session_ctrl.md
# game_session_ctrl

Session sequencer for the memory-tester game; sits between login/authentication, the pattern-round logic, and `score_table`. It drives `score_table`'s `win`, `loose`, `level_num` and `log_out` inputs. After login it steps a user through levels 1..MAX_LEVEL, tracks remaining lives and enforces settle/gap spacing so the score table sees stable levels and single-cycle result pulses. It ends the session on game over or on user logout.

## Interface
Parameters:
- MAX_LEVEL, 5, highest level; after a pass at MAX_LEVEL the level wraps to 1
- MAX_LIVES, 3, failures allowed per session (1..3)
- SETTLE, 2, cycles between `level_num` update and `round_start`
- GAP, 3, idle cycles after a win/loose pulse before the next level load
- TIMEOUT_CYCLES, 1024, round time limit; used only with ROUND_TIMEOUT_EN

Ports:
- clock  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- green_user  in  1  login request, sampled in IDLE
- internal_id  in  3  user id, latched with green_user
- auth_bit  in  1  authentication granted
- user_logout  in  1  user logout request, level-sensitive
- round_done  in  1  one-cycle pulse from pattern logic: round finished
- round_pass  in  1  qualifies round_done: 1=pass, 0=fail
- round_start  out  1  one-cycle pulse: start pattern round
- level_num  out  4  current level to score_table and pattern logic
- win  out  1  one-cycle pass pulse to score_table
- loose  out  1  one-cycle fail pulse to score_table
- log_out  out  1  one-cycle session-end pulse to score_table
- user_id  out  3  latched internal_id
- lives  out  2  remaining lives
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, AUTH, LOAD, SETTLE_W, PLAY, RESULT, END.
- IDLE: level_num=0, lives=MAX_LIVES.
  - green_user=1 → latch internal_id into user_id, go to AUTH.
- AUTH:
  - auth_bit=1 → level_num=1, go to LOAD.
  - user_logout → END.
- LOAD: one cycle, then SETTLE_W.
- SETTLE_W: counts SETTLE cycles, then pulses round_start for one cycle and enters PLAY.
- PLAY: waits for round_done.
  - Pass: pulse win. level_num = (level_num==MAX_LEVEL) ? 1 : level_num+1.
  - Fail: pulse loose, lives−1, level_num unchanged.
  - Either result → RESULT.
- RESULT: counts GAP cycles.
  - lives==0 → END.
  - Otherwise → LOAD.
- END: pulses log_out for one cycle, clears user_id, level_num=0, lives=MAX_LIVES, then IDLE.
- user_logout in LOAD, SETTLE_W, PLAY or RESULT → END next edge.
  - Takes priority over a simultaneous round_done: no win/loose is emitted, lives unchanged.
- round_done outside PLAY is ignored. round_pass is ignored without round_done.
- win, loose and log_out are mutually exclusive; at most one is high in any cycle.
- Arithmetic: level_num is a 4-bit register that never reaches 0 while in a session. lives saturates at 0.

## Timing
- Reset (rst=0 at an edge): state=IDLE; win=loose=log_out=round_start=busy=0; level_num=0; user_id=0; lives=MAX_LIVES. Applies regardless of the current state.
- auth_bit sampled high at edge N: level_num=1 after N. round_start is high in cycle N+2+SETTLE.
- round_done sampled at edge M: win or loose is high in cycle M+1 only. The updated level_num is visible in the same cycle.
- The next round_start follows GAP+1+SETTLE+1 cycles after the win/loose cycle.
- user_logout sampled at edge K: log_out is high in cycle K+1. busy=0 from cycle K+2.
- The last fail: loose at M+1, log_out after GAP more cycles.

## Configuration
- ROUND_TIMEOUT_EN defined:
  - A cycle counter runs in PLAY.
  - Reaching TIMEOUT_CYCLES without round_done is treated as a fail (loose pulse, lives−1), with identical timing.
  - The counter clears on leaving PLAY.
- ROUND_TIMEOUT_EN undefined: no counter; PLAY waits indefinitely.

## Test plan
- Login and pass sequence:
  - Stimulus: rst low then high, green_user=1 with id=3'b101, auth_bit=1, then 5 passes.
  - Required: level_num steps 1,2,3,4,5 then wraps to 1. Five single-cycle win pulses. user_id=5.
- Lives exhausted (MAX_LIVES=3):
  - Stimulus: three failing rounds at level 2.
  - Required: three loose pulses; lives goes 2,1,0; level_num stays 2. log_out fires GAP cycles after the third loose, then IDLE with busy=0.
- Logout collision:
  - Stimulus: user_logout and round_done/round_pass=1 in the same cycle.
  - Required: log_out only, no win; level_num=0 afterwards.
- Reset mid-play:
  - Stimulus: rst=0 while in PLAY at level 3.
  - Required: next edge gives all outputs at reset values, lives=3, no log_out pulse.
- Spacing:
  - Check that round_start fires exactly SETTLE=2 cycles after LOAD.
  - Check that round_done outside PLAY produces no pulse.
- With ROUND_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Stimulus: no round_done for 16 cycles.
  - Required: loose pulse, lives decrements, next round_start follows.
